// File: rtl/module_mux_scan_if.sv
// Display bus for module_mux_scan: captured data/flags in, registered
// segment/anode/mode outputs back.
interface module_mux_scan_if #(
    parameter int N_DIG = 4
);
    logic                 load_i;
    logic [7*N_DIG-1:0]   word_seg_i;
    logic [7*N_DIG-1:0]   err_seg_i;
    logic                 swi;
    logic                 error_simple;
    logic                 error_doble;
    logic                 no_error;
    logic [6:0]           seg_o;
    logic [N_DIG-1:0]     an_o;
    logic [1:0]           mode_o;

    // Driver side (decoder / bench)
    modport master (
        output load_i, word_seg_i, err_seg_i, swi,
        output error_simple, error_doble, no_error,
        input  seg_o, an_o, mode_o
    );

    // Display controller side
    modport slave (
        input  load_i, word_seg_i, err_seg_i, swi,
        input  error_simple, error_doble, no_error,
        output seg_o, an_o, mode_o
    );
endinterface

// File: rtl/module_mux_scan.sv
// Multiplexed 7-segment scanner. Shows either the corrected word or the
// error/syndrome pattern depending on captured decoder flags, and blinks
// the error pattern when a double error was captured.
module module_mux_scan #(
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 27000,
    parameter int BLINK_DIV = 13500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    module_mux_scan_if.slave     bus
);
    localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (N_DIG     > 1) ? $clog2(N_DIG)     : 1;

    logic [7*N_DIG-1:0]    r_word;
    logic [7*N_DIG-1:0]    r_err;
    logic                  r_es;
    logic                  r_ed;
    logic                  r_ne;
    logic                  r_swi;
    logic [DW-1:0]         r_div;
    logic [IW-1:0]         r_idx;
    logic [BW-1:0]         r_bcnt;
    logic                  r_phase;
    logic [6:0]            r_seg;
    logic [N_DIG-1:0]      r_an;
    logic [1:0]            r_mode;

    logic                  w_div_wrap;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_blink_wrap;
    logic                  w_src_err;
    logic [N_DIG-1:0][6:0] w_src;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [N_DIG-1:0]      w_an;
    logic [1:0]            w_mode;

    // Capture decoder data and flags on the load strobe; hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
            r_err  <= '0;
            r_es   <= 1'b0;
            r_ed   <= 1'b0;
            r_ne   <= 1'b0;
        end else if (bus.load_i) begin
            r_word <= bus.word_seg_i;
            r_err  <= bus.err_seg_i;
            r_es   <= bus.error_simple;
            r_ed   <= bus.error_doble;
            r_ne   <= bus.no_error;
        end
    end

    // swi is a live switch, so it gets one register stage of its own
    always_ff @(posedge clk) begin
        if (!rst_n) r_swi <= 1'b0;
        else        r_swi <= bus.swi;
    end

    assign w_div_wrap = (r_div == DW'(SCAN_DIV - 1));
    assign w_idx_nxt  = (r_idx == IW'(N_DIG - 1)) ? '0 : r_idx + 1'b1;

    // Free-running scan divider and digit index; loads never disturb them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_idx <= w_idx_nxt;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_blink_wrap = (r_bcnt == BW'(BLINK_DIV - 1));

    // Blink timer runs only while a double error is held; a new load
    // restarts it in the on phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (bus.load_i || !r_ed) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_blink_wrap) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    // Source priority: double error > simple error > no error > switch.
    // Simultaneous flags are resolved by this order alone.
    always_comb begin
        w_src_err = 1'b0;
        if (r_ed)      w_src_err = 1'b1;
        else if (r_es) w_src_err = 1'b0;
        else if (r_ne) w_src_err = 1'b0;
        else           w_src_err = r_swi;
    end

    assign w_src   = w_src_err ? r_err : r_word;
    assign w_blank = ~r_phase;
    assign w_an    = ~(N_DIG'(1) << r_idx);

    // Segment/mode selection for the active digit, blanked in the off phase
    always_comb begin
        w_seg  = w_src[r_idx];
        w_mode = w_src_err ? 2'd1 : 2'd0;
        if (w_blank) begin
            w_seg  = 7'h00;
            w_mode = 2'd2;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg  <= 7'h00;
            r_an   <= '1;
            r_mode <= 2'd0;
        end else begin
            r_seg  <= w_seg;
            r_an   <= w_an;
            r_mode <= w_mode;
        end
    end

    assign bus.seg_o  = r_seg;
    assign bus.an_o   = r_an;
    assign bus.mode_o = r_mode;
endmodule
